// File: rtl/routing_lookup_arbiter_if.sv
// ----------------------------------------------------------------------------
// routing_lookup_arbiter_if
//
// Purpose: bundles every non-clock/reset signal of routing_lookup_arbiter:
// the per-requester lookup request channel, the routing-table lookup port
// and the valid/ready response channel.
//
// Signals:
//   req_valid   [REQ_N]      requester -> arbiter, lookup request (held)
//   req_ready   [REQ_N]      arbiter -> requester, one-hot accept pulse
//   req_dest    [REQ_N*24]   packed destination addresses, req i at [24*i +: 24]
//   req_src     [REQ_N*4]    packed source ids, req i at [4*i +: 4]
//   tbl_destination_address  arbiter -> table
//   tbl_source_id            arbiter -> table
//   tbl_routing_opcode       table -> arbiter, 1-cycle registered read
//   resp_valid / resp_ready  response handshake
//   resp_opcode, resp_req_id, resp_error  response payload
//   busy                     arbiter not idle
//
// Modports: slave = arbiter side, master = requesters/table/consumer side.
// ----------------------------------------------------------------------------
interface routing_lookup_arbiter_if #(
    parameter int REQ_N = 4,
    parameter int ID_W  = 2
);
    logic [REQ_N-1:0]    req_valid;
    logic [REQ_N-1:0]    req_ready;
    logic [REQ_N*24-1:0] req_dest;
    logic [REQ_N*4-1:0]  req_src;

    logic [23:0]         tbl_destination_address;
    logic [3:0]          tbl_source_id;
    logic [27:0]         tbl_routing_opcode;

    logic                resp_valid;
    logic                resp_ready;
    logic [27:0]         resp_opcode;
    logic [ID_W-1:0]     resp_req_id;
    logic                resp_error;
    logic                busy;

    modport slave (
        input  req_valid, req_dest, req_src, tbl_routing_opcode, resp_ready,
        output req_ready, tbl_destination_address, tbl_source_id,
               resp_valid, resp_opcode, resp_req_id, resp_error, busy
    );

    modport master (
        output req_valid, req_dest, req_src, tbl_routing_opcode, resp_ready,
        input  req_ready, tbl_destination_address, tbl_source_id,
               resp_valid, resp_opcode, resp_req_id, resp_error, busy
    );
endinterface

// File: rtl/routing_lookup_arbiter.sv
// ----------------------------------------------------------------------------
// routing_lookup_arbiter
//
// Purpose: shares one single-ported routing table among REQ_N requesters.
// A round-robin arbiter accepts one request at a time, drives the table
// inputs, waits out the table's 1-cycle registered read and returns the
// 28-bit routing opcode on a valid/ready response channel.
//
// Ports:
//   clk      clock, all state changes on the rising edge
//   reset_n  synchronous active-low reset
//   bus      routing_lookup_arbiter_if.slave (request, table, response, busy)
//
// Optional feature (macro ROUTE_RANGE_CHECK_EN): when defined, the table
// index idx = dest + src*NODES + 1 is checked at accept; out-of-range
// requests skip the table and answer one cycle later with resp_opcode=0,
// resp_error=1. When undefined, resp_error stays 0 and every request
// performs a lookup.
// ----------------------------------------------------------------------------
module routing_lookup_arbiter #(
    parameter int REQ_N       = 4,
    parameter int NODES       = 4,
    parameter int TABLE_DEPTH = 64,
    parameter int ID_W        = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    routing_lookup_arbiter_if.slave  bus
);

    // Elaboration-time guard against inconsistent parameter sets.
    if (ID_W != $clog2(REQ_N) || REQ_N < 2 || REQ_N > 8 ||
        NODES < 1 || TABLE_DEPTH < 1) begin : g_param_check
        $error("routing_lookup_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOOKUP  = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [23:0]     tbl_dest_q, tbl_dest_d;
    logic [3:0]      tbl_src_q, tbl_src_d;
    logic [27:0]     resp_opcode_q, resp_opcode_d;
    logic [ID_W-1:0] resp_req_id_q, resp_req_id_d;
    logic            resp_error_q, resp_error_d;

    logic            grant_found;
    logic [ID_W-1:0] grant_idx;
    logic [ID_W-1:0] cand;
    logic [REQ_N-1:0] req_ready_c;
    logic [23:0]     sel_dest;
    logic [3:0]      sel_src;
    logic            range_bad;

    // Round-robin search: first asserted requester starting at rr_ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < REQ_N; k++) begin
            cand = ID_W'((int'(rr_ptr_q) + k) % REQ_N);
            if (!grant_found && bus.req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    assign sel_dest = bus.req_dest[24*grant_idx +: 24];
    assign sel_src  = bus.req_src[4*grant_idx +: 4];

`ifdef ROUTE_RANGE_CHECK_EN
    // Full 32-bit index so large dest values cannot wrap into range.
    logic [31:0] lookup_idx;
    assign lookup_idx = {8'd0, sel_dest} + (32'(sel_src) * 32'(NODES)) + 32'd1;
    assign range_bad  = (lookup_idx < 32'd1) || (lookup_idx > 32'(TABLE_DEPTH));
`else
    assign range_bad  = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        tbl_dest_d    = tbl_dest_q;
        tbl_src_d     = tbl_src_q;
        resp_opcode_d = resp_opcode_q;
        resp_req_id_d = resp_req_id_q;
        resp_error_d  = resp_error_q;
        req_ready_c   = '0;

        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    req_ready_c[grant_idx] = 1'b1;
                    resp_req_id_d          = grant_idx;
                    rr_ptr_d               = ID_W'((int'(grant_idx) + 1) % REQ_N);
                    if (range_bad) begin
                        // Table untouched; answer directly with an error.
                        resp_opcode_d = '0;
                        resp_error_d  = 1'b1;
                        state_d       = RESP;
                    end else begin
                        tbl_dest_d = sel_dest;
                        tbl_src_d  = sel_src;
                        state_d    = LOOKUP;
                    end
                end
            end
            LOOKUP: begin
                // Table registers tbl_* at the end of this cycle.
                state_d = CAPTURE;
            end
            CAPTURE: begin
                resp_opcode_d = bus.tbl_routing_opcode;
                resp_error_d  = 1'b0;
                state_d       = RESP;
            end
            RESP: begin
                if (bus.resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= '0;
            tbl_dest_q    <= '0;
            tbl_src_q     <= '0;
            resp_opcode_q <= '0;
            resp_req_id_q <= '0;
            resp_error_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            tbl_dest_q    <= tbl_dest_d;
            tbl_src_q     <= tbl_src_d;
            resp_opcode_q <= resp_opcode_d;
            resp_req_id_q <= resp_req_id_d;
            resp_error_q  <= resp_error_d;
        end
    end

    // No accept may be signalled while reset is asserted, even though the
    // state register already reads IDLE.
    assign bus.req_ready               = reset_n ? req_ready_c : '0;
    assign bus.tbl_destination_address = tbl_dest_q;
    assign bus.tbl_source_id           = tbl_src_q;
    assign bus.resp_valid              = (state_q == RESP);
    assign bus.resp_opcode             = resp_opcode_q;
    assign bus.resp_req_id             = resp_req_id_q;
    assign bus.resp_error              = resp_error_q;
    assign bus.busy                    = (state_q != IDLE);

endmodule

// File: tb/tb_routing_lookup_arbiter.sv
// ----------------------------------------------------------------------------
// tb_routing_lookup_arbiter
//
// Directed bench for routing_lookup_arbiter. The stimulus process queues the
// hand-computed response it expects for each request; a monitor pops and
// compares on every response handshake. A behavioural table returns
// 28'h0ABCDEF for entry 10 and {4'h5, idx[23:0]} for every other entry.
// ----------------------------------------------------------------------------
module tb_routing_lookup_arbiter;
    localparam int REQ_N = 4;
    localparam int ID_W  = 2;

    logic clk = 1'b0;
    logic reset_n;

    routing_lookup_arbiter_if #(.REQ_N(REQ_N), .ID_W(ID_W)) bus ();

    routing_lookup_arbiter #(
        .REQ_N(REQ_N), .NODES(4), .TABLE_DEPTH(64), .ID_W(ID_W)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [27:0]     op;
        logic [ID_W-1:0] id;
        logic            err;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    endtask

    // Behavioural routing table with a registered read.
    function automatic logic [27:0] tbl_entry(input logic [31:0] idx);
        if (idx == 32'd10) return 28'h0ABCDEF;
        return {4'h5, idx[23:0]};
    endfunction

    always @(posedge clk)
        bus.tbl_routing_opcode <= tbl_entry({8'd0, bus.tbl_destination_address}
                                            + {28'd0, bus.tbl_source_id} * 32'd4 + 32'd1);

    // Response monitor: settles 1 time unit after the falling edge.
    always @(negedge clk) begin
        #1;
        if (reset_n === 1'b1 && bus.resp_valid === 1'b1 && bus.resp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("resp_unexpected_qdepth", 32'(exp_q.size()), 32'd1);
            end else begin
                mon_e = exp_q.pop_front();
                check("resp_opcode", 32'(bus.resp_opcode), 32'(mon_e.op));
                check("resp_req_id", 32'(bus.resp_req_id), 32'(mon_e.id));
                check("resp_error",  32'(bus.resp_error),  32'(mon_e.err));
            end
        end
    end

    initial begin
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog: cycle %0d reached, expected completion before it", cyc);
        $fatal(1);
    end

    task automatic set_req(input int r, input logic [23:0] d, input logic [3:0] s);
        bus.req_dest[24*r +: 24] = d;
        bus.req_src[4*r +: 4]    = s;
    endtask

    task automatic push(input logic [27:0] op, input int id, input logic err);
        exp_t e;
        e.op  = op;
        e.id  = ID_W'(id);
        e.err = err;
        exp_q.push_back(e);
    endtask

    // Waits (bounded) for an accept, checks it is the expected requester,
    // then moves to the falling edge after the accept edge.
    task automatic wait_grant(input string nm, input int exp_id, input bit drop, output int at);
        int n;
        n = 0;
        #1;
        while (bus.req_ready == '0 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        at = cyc;
        check({nm, "_grant"}, 32'(bus.req_ready), 32'(1 << exp_id));
        @(negedge clk);
        if (drop) bus.req_valid[exp_id] = 1'b0;
    endtask

    // Called on the first falling edge after an accept.
    task automatic wait_lat(input string nm, input int lat);
        int n;
        n = 1;
        while (bus.resp_valid !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        check(nm, 32'(n), 32'(lat));
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.busy !== 1'b0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({nm, "_drain_q"}, 32'(exp_q.size()), 32'd0);
        check({nm, "_drain_busy"}, 32'(bus.busy), 32'd0);
    endtask

    int t, prev;

    initial begin
        reset_n        = 1'b0;
        bus.req_valid  = '0;
        bus.req_dest   = '0;
        bus.req_src    = '0;
        bus.resp_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state, with requests pending to show no accept leaks out.
        bus.req_valid = 4'hF;
        #1;
        check("rst_req_ready",   32'(bus.req_ready), 32'd0);
        check("rst_resp_valid",  32'(bus.resp_valid), 32'd0);
        check("rst_busy",        32'(bus.busy), 32'd0);
        check("rst_resp_opcode", 32'(bus.resp_opcode), 32'd0);
        check("rst_resp_req_id", 32'(bus.resp_req_id), 32'd0);
        check("rst_resp_error",  32'(bus.resp_error), 32'd0);
        check("rst_tbl_dest",    32'(bus.tbl_destination_address), 32'd0);
        check("rst_tbl_src",     32'(bus.tbl_source_id), 32'd0);
        @(negedge clk);
        bus.req_valid = '0;
        reset_n       = 1'b1;
        @(negedge clk);

        // Single lookup: req0 dest=5 src=1 -> idx 10.
        set_req(0, 24'd5, 4'd1);
        push(28'h0ABCDEF, 0, 1'b0);
        bus.req_valid = 4'b0001;
        wait_grant("single", 0, 1'b1, t);
        check("single_tbl_dest",   32'(bus.tbl_destination_address), 32'd5);
        check("single_tbl_src",    32'(bus.tbl_source_id), 32'd1);
        check("single_busy",       32'(bus.busy), 32'd1);
        check("single_resp_early", 32'(bus.resp_valid), 32'd0);
        wait_lat("single_lat", 3);
        drain("single");

        // Round robin, all four held; rr_ptr is 1 after the single lookup.
        // idx(i) = (i+1) + 4*i + 1 = 5i+2.
        for (int i = 0; i < REQ_N; i++) set_req(i, 24'(i + 1), 4'(i));
        push(28'h5000007, 1, 1'b0);
        push(28'h500000C, 2, 1'b0);
        push(28'h5000011, 3, 1'b0);
        push(28'h5000002, 0, 1'b0);
        push(28'h5000007, 1, 1'b0);
        bus.req_valid = 4'hF;
        prev = 0;
        for (int g = 0; g < 5; g++) begin
            wait_grant($sformatf("rr%0d", g), (g + 1) % REQ_N, 1'b0, t);
            if (g > 0) check($sformatf("rr%0d_spacing", g), 32'(t - prev), 32'd4);
            prev = t;
        end
        bus.req_valid = '0;
        drain("rr");

        // Backpressure: rr_ptr=2; req2 (idx 11) served, req3 (idx 1) waits.
        set_req(2, 24'd2, 4'd2);
        set_req(3, 24'd0, 4'd0);
        push(28'h500000B, 2, 1'b0);
        push(28'h5000001, 3, 1'b0);
        bus.resp_ready = 1'b0;
        bus.req_valid  = 4'b1100;
        wait_grant("bp_a", 2, 1'b1, t);
        wait_lat("bp_lat", 3);
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("bp_valid%0d", k),  32'(bus.resp_valid), 32'd1);
            check($sformatf("bp_opcode%0d", k), 32'(bus.resp_opcode), 32'h500000B);
            check($sformatf("bp_id%0d", k),     32'(bus.resp_req_id), 32'd2);
            check($sformatf("bp_ready%0d", k),  32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_idle_busy", 32'(bus.busy), 32'd0);
        wait_grant("bp_b", 3, 1'b1, t);
        check("bp_b_busy", 32'(bus.busy), 32'd1);
        wait_lat("bp_b_lat", 3);
        drain("bp");

        // Fairness: rr_ptr=0; req1 continuous (idx 8), req3 joins during RESP (idx 13).
        set_req(1, 24'd7, 4'd0);
        set_req(3, 24'd0, 4'd3);
        push(28'h5000008, 1, 1'b0);
        push(28'h500000D, 3, 1'b0);
        push(28'h5000008, 1, 1'b0);
        bus.req_valid = 4'b0010;
        wait_grant("fair_a", 1, 1'b0, t);
        wait_lat("fair_a_lat", 3);
        bus.req_valid[3] = 1'b1;
        wait_grant("fair_b", 3, 1'b1, t);
        wait_grant("fair_c", 1, 1'b1, t);
        drain("fair");

        // Range: req2 dest=60 src=3 -> idx 73 (above TABLE_DEPTH).
        set_req(2, 24'd60, 4'd3);
        bus.req_valid = 4'b0100;
`ifdef ROUTE_RANGE_CHECK_EN
        push(28'h0, 2, 1'b1);
        wait_grant("rng_hi", 2, 1'b1, t);
        wait_lat("rng_hi_lat", 1);
        check("rng_hi_tbl_dest", 32'(bus.tbl_destination_address), 32'd7);
        check("rng_hi_tbl_src",  32'(bus.tbl_source_id), 32'd0);
`else
        push(28'h5000049, 2, 1'b0);
        wait_grant("rng_hi", 2, 1'b1, t);
        check("rng_hi_tbl_dest", 32'(bus.tbl_destination_address), 32'd60);
        check("rng_hi_tbl_src",  32'(bus.tbl_source_id), 32'd3);
        wait_lat("rng_hi_lat", 3);
`endif
        drain("rng_hi");

        // Range edge: dest=63 src=0 -> idx 64, always a normal lookup.
        set_req(2, 24'd63, 4'd0);
        push(28'h5000040, 2, 1'b0);
        bus.req_valid = 4'b0100;
        wait_grant("rng_edge", 2, 1'b1, t);
        check("rng_edge_tbl_dest", 32'(bus.tbl_destination_address), 32'd63);
        wait_lat("rng_edge_lat", 3);
        drain("rng_edge");

        // Reset mid-RESP: req1 lookup abandoned (rr_ptr would become 2).
        set_req(1, 24'd1, 4'd1);
        set_req(0, 24'd0, 4'd2);
        set_req(2, 24'd3, 4'd0);
        bus.resp_ready = 1'b0;
        bus.req_valid  = 4'b0010;
        wait_grant("rst_a", 1, 1'b1, t);
        wait_lat("rst_a_lat", 3);
        reset_n       = 1'b0;
        bus.req_valid = 4'b0101;
        repeat (3) @(negedge clk);
        #1;
        check("rst2_resp_valid",  32'(bus.resp_valid), 32'd0);
        check("rst2_busy",        32'(bus.busy), 32'd0);
        check("rst2_req_ready",   32'(bus.req_ready), 32'd0);
        check("rst2_resp_opcode", 32'(bus.resp_opcode), 32'd0);
        @(negedge clk);
        bus.resp_ready = 1'b1;
        reset_n        = 1'b1;
        // rr_ptr=0 after reset: req0 (idx 9) first, then req2 (idx 4).
        push(28'h5000009, 0, 1'b0);
        push(28'h5000004, 2, 1'b0);
        wait_grant("rst_b", 0, 1'b1, t);
        wait_lat("rst_b_lat", 3);
        wait_grant("rst_c", 2, 1'b1, t);
        wait_lat("rst_c_lat", 3);
        drain("rst");

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/routing_lookup_arbiter.md
Name: routing_lookup_arbiter

Overview:
- Shares the single-ported routing-table lookup among REQ_N requesters (GW ingress ports, TT/ET schedulers).
- Round-robin arbitration; one lookup in flight at a time.
- Drives the table's destination_address/source_id inputs, waits out its 1-cycle registered read, returns the 28-bit routing opcode to the granted requester over a valid/ready response channel.

Parameters:
- REQ_N, 4, number of requesters (2..8).
- NODES, 4, node count used in table index arithmetic.
- TABLE_DEPTH, 64, number of table entries, indexed 1..TABLE_DEPTH.
- ID_W, 2, width of resp_req_id (must equal clog2(REQ_N)).

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous active-low reset
- req_valid  in  REQ_N  per-requester lookup request
- req_ready  out  REQ_N  one-hot accept pulse
- req_dest  in  REQ_N*24  packed destination addresses; requester i at [24*i +: 24]
- req_src  in  REQ_N*4  packed source ids; requester i at [4*i +: 4]
- tbl_destination_address  out  24  to table
- tbl_source_id  out  4  to table
- tbl_routing_opcode  in  28  from table; valid 1 cycle after tbl_* sampled
- resp_valid  out  1  response available
- resp_ready  in  1  response consumer ready
- resp_opcode  out  28  looked-up opcode
- resp_req_id  out  ID_W  index of served requester
- resp_error  out  1  index out of range (see Optional Feature)
- busy  out  1  high in any state except IDLE

Behaviour:
- Clocking and reset:
  - All state changes on posedge clk.
  - reset_n=0 at an edge: state=IDLE, rr_ptr=0; req_ready=0, resp_valid=0, resp_opcode=0, resp_req_id=0, resp_error=0, tbl_destination_address=0, tbl_source_id=0, busy=0.
  - Reset mid-operation abandons the lookup. No response is produced and a pending resp_valid drops.
- FSM states: IDLE, LOOKUP, CAPTURE, RESP.
- IDLE:
  - If any req_valid, grant the first asserted requester searching rr_ptr, rr_ptr+1, ... mod REQ_N.
  - req_ready is combinational: it is high for the granted bit in the same cycle, only in IDLE. Accept happens on that edge.
  - Latch dest/src into tbl_* registers and the grant index into resp_req_id.
  - Set rr_ptr = (grant+1) mod REQ_N, go to LOOKUP.
  - No req_valid: stay in IDLE, rr_ptr unchanged.
- LOOKUP: tbl_* held stable; the table samples them at this edge. Go to CAPTURE.
- CAPTURE: resp_opcode <= tbl_routing_opcode, resp_error <= 0. Go to RESP.
- RESP:
  - resp_valid=1; resp_opcode/resp_req_id/resp_error held stable.
  - On resp_valid & resp_ready: go to IDLE, resp_valid=0 next cycle.
- Latency and throughput:
  - Accept edge to resp_valid high is 3 cycles.
  - Earliest next accept is the cycle after the response handshake, so at most one lookup per 4 cycles.
- req_ready is never asserted outside IDLE. Requests arriving during LOOKUP/CAPTURE/RESP wait; req_valid must be held by requesters.
- Simultaneous requests: exactly one granted per accept. With all REQ_N continuously requesting, grants rotate 0,1,2,...,REQ_N-1,0.
- Index arithmetic: idx = dest + src*NODES + 1, computed at 32 bits with no truncation.

Optional Feature:
- Macro: ROUTE_RANGE_CHECK_EN.
- Defined:
  - In IDLE at accept, idx is evaluated. If idx < 1 or idx > TABLE_DEPTH, go straight to RESP next cycle, skipping LOOKUP/CAPTURE.
  - That response has resp_opcode=0, resp_error=1 (latency 1 cycle); tbl_* are not updated.
  - In-range requests behave as above with resp_error=0.
- Not defined: no check logic, resp_error tied 0, every request performs a lookup.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles mid-RESP -> resp_valid=0, busy=0, rr_ptr=0. First request after release from req 2 alone is granted with resp_req_id=2.
- Single lookup: req0 dest=5, src=1, table entry 10=28'h0ABCDEF:
  - tbl_destination_address=5, tbl_source_id=1 from the cycle after accept.
  - resp_valid 3 cycles after accept with resp_opcode=28'h0ABCDEF, resp_req_id=0.
- Round robin: all 4 req_valid held high, resp_ready=1 -> resp_req_id sequence 0,1,2,3,0; grants spaced 4 cycles apart.
- Backpressure: resp_ready=0 for 5 cycles in RESP -> outputs stable, req_ready stays 0 despite req_valid. resp_ready=1 -> IDLE next cycle, accept on the following edge.
- Range check (ROUTE_RANGE_CHECK_EN): dest=60, src=3 (idx=73) -> resp_valid 1 cycle after accept, resp_error=1, resp_opcode=0, tbl_* unchanged. dest=63, src=0 (idx=64) -> normal lookup, resp_error=0.
- Fairness under churn: req1 continuous, req3 pulses on for 1 request while req1 is in RESP -> req3 served next, before req1's second grant.
